// File: rtl/tx_sequencer_if.sv
// Packet request, TX FIFO and line-encoder signals of the USB TX sequencer.
interface tx_sequencer_if;
    logic       tx_start;
    logic [7:0] tx_pid;
    logic [6:0] tx_byte_count;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_read;
    logic       serial_bit;
    logic       eop;
    logic       shift;
    logic       busy;
    logic       tx_done;
    logic       tx_error;

    modport slave (
        input  tx_start, tx_pid, tx_byte_count, fifo_data, fifo_empty,
        output fifo_read, serial_bit, eop, shift, busy, tx_done, tx_error
    );

    modport master (
        output tx_start, tx_pid, tx_byte_count, fifo_data, fifo_empty,
        input  fifo_read, serial_bit, eop, shift, busy, tx_done, tx_error
    );
endinterface

// File: rtl/tx_sequencer.sv
// USB packet TX sequencer: SYNC, PID, payload, optional CRC16, EOP with bit stuffing.
// Define TX_CRC16_EN to append the inverted CRC16 of the payload.
module tx_sequencer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    tx_sequencer_if.slave bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_PID  = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
`ifdef TX_CRC16_EN
    localparam logic [2:0] ST_CRC  = 3'd4;
`endif
    localparam logic [2:0] ST_EOP  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    idx_q, idx_d;
    logic [6:0]    rem_q, rem_d;
    logic [7:0]    pid_q, pid_d;
    logic [7:0]    data_q, data_d;
    logic [2:0]    ones_q, ones_d;
    logic          stuff_q, stuff_d;
    logic [1:0]    eop_cnt_q, eop_cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          shift_q, shift_d;
    logic          sbit_q, sbit_d;
    logic          eop_q, eop_d;
    logic          strobe_s;
    logic          load_s;
`ifdef TX_CRC16_EN
    logic [15:0]   crc_q, crc_d;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[15] ^ b;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    endfunction
`endif

    // Bit timer, packet pointer, stuffing and EOP sequencing.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        pid_d     = pid_q;
        data_d    = data_q;
        ones_d    = ones_q;
        stuff_d   = stuff_q;
        eop_cnt_d = eop_cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        load_s    = 1'b0;
`ifdef TX_CRC16_EN
        crc_d     = crc_q;
`endif
        strobe_s  = busy_q && (timer_q == TMAX);
        if (!busy_q) begin
            timer_d = TW'(0);
            if (bus.tx_start) begin
                state_d   = ST_SYNC;
                busy_d    = 1'b1;
                idx_d     = 4'd0;
                pid_d     = bus.tx_pid;
                rem_d     = bus.tx_byte_count;
                ones_d    = 3'd0;
                stuff_d   = 1'b0;
                eop_cnt_d = 2'd0;
`ifdef TX_CRC16_EN
                crc_d     = 16'hFFFF;
`endif
            end else begin
                state_d = ST_IDLE;
            end
        end else if (!strobe_s) begin
            timer_d = timer_q + TW'(1);
        end else if (stuff_q) begin
            // A stuffed zero consumes a bit period without moving the pointer.
            timer_d = TW'(0);
            stuff_d = 1'b0;
            ones_d  = 3'd0;
        end else if (state_q == ST_EOP) begin
            timer_d = TW'(0);
            if (eop_cnt_q == 2'd2) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                eop_cnt_d = eop_cnt_q + 2'd1;
            end
        end else begin
            timer_d = TW'(0);
            ones_d  = sbit_q ? (ones_q + 3'd1) : 3'd0;
            stuff_d = sbit_q && (ones_q == 3'd5);
            idx_d   = idx_q + 4'd1;
            case (state_q)
                ST_SYNC: begin
                    if (idx_q == 4'd7) begin
                        state_d = ST_PID;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_PID, ST_DATA: begin
`ifdef TX_CRC16_EN
                    if (state_q == ST_DATA) begin
                        crc_d = crc16_step(crc_q, sbit_q);
                    end else begin
                        crc_d = crc_q;
                    end
`endif
                    if (idx_q == 4'd7) begin
                        idx_d = 4'd0;
                        if (rem_q != 7'd0) begin
                            // An empty FIFO here is an underrun: abandon the payload and CRC.
                            load_s = 1'b1;
                            if (bus.fifo_empty) begin
                                state_d = ST_EOP;
                            end else begin
                                state_d = ST_DATA;
                                data_d  = bus.fifo_data;
                                rem_d   = rem_q - 7'd1;
                            end
                        end else begin
`ifdef TX_CRC16_EN
                            state_d = ST_CRC;
`else
                            state_d = ST_EOP;
`endif
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
`ifdef TX_CRC16_EN
                ST_CRC: begin
                    if (idx_q == 4'd15) begin
                        state_d = ST_EOP;
                        idx_d   = 4'd0;
                    end else begin
                        state_d = ST_CRC;
                    end
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Line outputs for the coming cycle, taken from the next state.
    always_comb begin
        shift_d = busy_d && (timer_d == TMAX);
        eop_d   = busy_d && (state_d == ST_EOP) && !stuff_d && (eop_cnt_d != 2'd2);
        if (!busy_d) begin
            sbit_d = 1'b1;
        end else if (stuff_d) begin
            sbit_d = 1'b0;
        end else begin
            case (state_d)
                ST_SYNC: sbit_d = (idx_d == 4'd7);
                ST_PID:  sbit_d = pid_d[idx_d[2:0]];
                ST_DATA: sbit_d = data_d[idx_d[2:0]];
`ifdef TX_CRC16_EN
                ST_CRC:  sbit_d = ~crc_d[idx_d];
`endif
                default: sbit_d = 1'b1;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= TW'(0);
            idx_q     <= 4'd0;
            rem_q     <= 7'd0;
            pid_q     <= 8'd0;
            data_q    <= 8'd0;
            ones_q    <= 3'd0;
            stuff_q   <= 1'b0;
            eop_cnt_q <= 2'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= 1'b0;
            sbit_q    <= 1'b1;
            eop_q     <= 1'b0;
`ifdef TX_CRC16_EN
            crc_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            pid_q     <= pid_d;
            data_q    <= data_d;
            ones_q    <= ones_d;
            stuff_q   <= stuff_d;
            eop_cnt_q <= eop_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            sbit_q    <= sbit_d;
            eop_q     <= eop_d;
`ifdef TX_CRC16_EN
            crc_q     <= crc_d;
`endif
        end
    end

    assign bus.fifo_read  = load_s && !bus.fifo_empty;
    assign bus.tx_error   = load_s && bus.fifo_empty;
    assign bus.serial_bit = sbit_q;
    assign bus.eop        = eop_q;
    assign bus.shift      = shift_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer against a bit-stream reference model.
module tb_tx_sequencer;
    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst;
    tx_sequencer_if bus();

    tx_sequencer #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned fifo_q[$];
    bit exp_bit[$], exp_eop[$], exp_rd[$], exp_err[$];
    int n_bits;

    task automatic fifo_update();
        bus.fifo_empty = (fifo_q.size() == 0);
        bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    // Expected bit periods: raw bits, then one zero after every six ones, then 3 EOP periods.
    task automatic build_model(input logic [7:0] pid, input int count);
        bit raw[$], rrd[$], rerr[$], dat[$];
        logic [7:0] b;
        logic [15:0] crc;
        bit fb, aborted;
        int run;
        exp_bit.delete(); exp_eop.delete(); exp_rd.delete(); exp_err.delete();
        for (int i = 0; i < 8; i++) begin raw.push_back(i == 7); rrd.push_back(1'b0); rerr.push_back(1'b0); end
        for (int i = 0; i < 8; i++) begin raw.push_back(pid[i]); rrd.push_back(1'b0); rerr.push_back(1'b0); end
        aborted = 1'b0;
        for (int j = 0; j < count && !aborted; j++) begin
            if (j < fifo_q.size()) begin
                rrd[rrd.size()-1] = 1'b1;
                b = fifo_q[j];
                for (int i = 0; i < 8; i++) begin
                    raw.push_back(b[i]); rrd.push_back(1'b0); rerr.push_back(1'b0); dat.push_back(b[i]);
                end
            end else begin
                rerr[rerr.size()-1] = 1'b1;
                aborted = 1'b1;
            end
        end
`ifdef TX_CRC16_EN
        if (!aborted) begin
            crc = 16'hFFFF;
            foreach (dat[k]) begin
                fb  = crc[15] ^ dat[k];
                crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
            for (int i = 0; i < 16; i++) begin raw.push_back(~crc[i]); rrd.push_back(1'b0); rerr.push_back(1'b0); end
        end
`endif
        run = 0;
        foreach (raw[i]) begin
            exp_bit.push_back(raw[i]); exp_eop.push_back(1'b0); exp_rd.push_back(rrd[i]); exp_err.push_back(rerr[i]);
            run = raw[i] ? run + 1 : 0;
            if (run == 6) begin
                exp_bit.push_back(1'b0); exp_eop.push_back(1'b0); exp_rd.push_back(1'b0); exp_err.push_back(1'b0);
                run = 0;
            end
        end
        n_bits = exp_bit.size();
        for (int i = 0; i < 3; i++) begin
            exp_bit.push_back(1'b1); exp_eop.push_back(i < 2); exp_rd.push_back(1'b0); exp_err.push_back(1'b0);
        end
    endtask

    task automatic run_packet(input logic [7:0] pid, input int count, input string name, input int repulse_at,
                              output int n_shift, output int n_reads);
        int total, p;
        bit pop, exp_shift;
        build_model(pid, count);
        total = exp_bit.size();
        n_shift = 0; n_reads = 0; pop = 1'b0;
        @(negedge clk);
        bus.tx_pid = pid; bus.tx_byte_count = 7'(count); bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0; bus.tx_pid = 8'($urandom); bus.tx_byte_count = 7'($urandom_range(0, 64));
        for (int c = 1; c <= CPB * total + 1; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                if (pop) begin void'(fifo_q.pop_front()); fifo_update(); end
                pop = 1'b0;
                @(negedge clk);
            end
            p = (c - 1) / CPB;
            if (c <= CPB * total) begin
                exp_shift = (c % CPB == 0);
                n_shift += int'(bus.shift === 1'b1);
                n_reads += int'(bus.fifo_read === 1'b1);
                n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL %s busy c=%0d got %b want 1", name, c, bus.busy); end
                n_cmp++; if (bus.shift !== exp_shift) begin n_bad++; $display("FAIL %s shift c=%0d got %b want %b", name, c, bus.shift, exp_shift); end
                if (p < n_bits) begin
                    n_cmp++; if (bus.serial_bit !== exp_bit[p]) begin n_bad++; $display("FAIL %s serial_bit c=%0d period=%0d got %b want %b", name, c, p, bus.serial_bit, exp_bit[p]); end
                end
                n_cmp++; if (bus.eop !== exp_eop[p]) begin n_bad++; $display("FAIL %s eop c=%0d period=%0d got %b want %b", name, c, p, bus.eop, exp_eop[p]); end
                n_cmp++; if (bus.fifo_read !== (exp_shift && exp_rd[p])) begin n_bad++; $display("FAIL %s fifo_read c=%0d got %b want %b", name, c, bus.fifo_read, exp_shift && exp_rd[p]); end
                n_cmp++; if (bus.tx_error !== (exp_shift && exp_err[p])) begin n_bad++; $display("FAIL %s tx_error c=%0d got %b want %b", name, c, bus.tx_error, exp_shift && exp_err[p]); end
                n_cmp++; if (bus.tx_done !== 1'b0) begin n_bad++; $display("FAIL %s tx_done early c=%0d got %b want 0", name, c, bus.tx_done); end
                pop = (bus.fifo_read === 1'b1);
            end else begin
                n_cmp++; if (bus.tx_done !== 1'b1) begin n_bad++; $display("FAIL %s tx_done c=%0d got %b want 1", name, c, bus.tx_done); end
                n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_end c=%0d got %b want 0", name, c, bus.busy); end
                n_cmp++; if (bus.serial_bit !== 1'b1) begin n_bad++; $display("FAIL %s idle_bit c=%0d got %b want 1", name, c, bus.serial_bit); end
            end
            if (c == repulse_at) begin
                bus.tx_start = 1'b1; bus.tx_pid = ~pid; bus.tx_byte_count = 7'd5;
            end else begin
                bus.tx_start = 1'b0;
            end
        end
        bus.tx_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.serial_bit !== 1'b1) begin n_bad++; $display("FAIL reset serial_bit got %b want 1", bus.serial_bit); end
        n_cmp++; if ({bus.busy, bus.shift, bus.eop, bus.tx_done, bus.tx_error, bus.fifo_read} !== 6'b0)
            begin n_bad++; $display("FAIL reset outputs got %b want 000000", {bus.busy, bus.shift, bus.eop, bus.tx_done, bus.tx_error, bus.fifo_read}); end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if ({bus.busy, bus.shift, bus.serial_bit} !== 3'b001) begin n_bad++; $display("FAIL idle outputs got %b want 001", {bus.busy, bus.shift, bus.serial_bit}); end
        end
    endtask

    task automatic test_basic_pid();
        int ns, nr;
        fifo_q.delete(); fifo_update();
        run_packet(8'h69, 0, "pid_only", 0, ns, nr);
`ifdef TX_CRC16_EN
        n_cmp++; if (ns !== 35) begin n_bad++; $display("FAIL pid_only strobes got %0d want 35", ns); end
`else
        n_cmp++; if (ns !== 19) begin n_bad++; $display("FAIL pid_only strobes got %0d want 19", ns); end
`endif
        run_packet(8'h4B, 0, "pid_4b", 0, ns, nr);
    endtask

    task automatic test_stuffing();
        int ns, nr;
        fifo_q.delete(); fifo_q.push_back(8'hFF); fifo_update();
        run_packet(8'hC3, 1, "stuff_ff", 0, ns, nr);
        n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL stuff_ff reads got %0d want 1", nr); end
`ifndef TX_CRC16_EN
        n_cmp++; if (ns !== 28) begin n_bad++; $display("FAIL stuff_ff strobes got %0d want 28", ns); end
`endif
        fifo_q.delete(); fifo_q.push_back(8'h3F); fifo_q.push_back(8'hFF); fifo_update();
        run_packet(8'hFF, 2, "stuff_pid_ff", 0, ns, nr);
    endtask

    task automatic test_random();
        int ns, nr, cnt;
        for (int i = 0; i < 6; i++) begin
            fifo_q.delete();
            cnt = $urandom_range(0, 5);
            for (int k = 0; k < cnt; k++) fifo_q.push_back(8'($urandom));
            fifo_update();
            run_packet(8'($urandom), cnt, "random", 0, ns, nr);
            n_cmp++; if (nr !== cnt) begin n_bad++; $display("FAIL random reads got %0d want %0d", nr, cnt); end
        end
        fifo_q.delete();
        for (int k = 0; k < 64; k++) fifo_q.push_back((k % 3 == 0) ? 8'($urandom) : 8'hFF);
        fifo_update();
        run_packet(8'($urandom), 64, "max_len", 0, ns, nr);
        n_cmp++; if (nr !== 64) begin n_bad++; $display("FAIL max_len reads got %0d want 64", nr); end
    endtask

    task automatic test_underrun();
        int ns, nr;
        fifo_q.delete(); fifo_q.push_back(8'($urandom)); fifo_update();
        run_packet(8'hA5, 2, "underrun_b2", 0, ns, nr);
        n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL underrun_b2 reads got %0d want 1", nr); end
        fifo_q.delete(); fifo_update();
        run_packet(8'h2D, 3, "underrun_pid", 0, ns, nr);
        n_cmp++; if (nr !== 0) begin n_bad++; $display("FAIL underrun_pid reads got %0d want 0", nr); end
    endtask

    task automatic test_restart_ignored();
        int ns, nr;
        fifo_q.delete(); fifo_q.push_back(8'($urandom)); fifo_q.push_back(8'($urandom)); fifo_update();
        run_packet(8'($urandom), 1, "restart_busy", 30, ns, nr);
        n_cmp++; if (nr !== 1) begin n_bad++; $display("FAIL restart_busy reads got %0d want 1", nr); end
    endtask

    task automatic test_reset_midpacket();
        int ns, nr, seen;
        fifo_q.delete();
        for (int k = 0; k < 4; k++) fifo_q.push_back(8'($urandom));
        fifo_update();
        @(negedge clk); bus.tx_pid = 8'h5A; bus.tx_byte_count = 7'd4; bus.tx_start = 1'b1;
        @(negedge clk); bus.tx_start = 1'b0;
        repeat (CPB * 20) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL midrst busy_before got %b want 1", bus.busy); end
        rst = 1'b1; #1;
        n_cmp++; if ({bus.busy, bus.shift, bus.eop, bus.fifo_read, bus.tx_done, bus.serial_bit} !== 6'b000001)
            begin n_bad++; $display("FAIL midrst outputs got %b want 000001", {bus.busy, bus.shift, bus.eop, bus.fifo_read, bus.tx_done, bus.serial_bit}); end
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (CPB * 8) begin
            @(negedge clk);
            seen += int'(bus.tx_done === 1'b1 || bus.fifo_read === 1'b1 || bus.busy === 1'b1);
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst activity got %0d cycles want 0", seen); end
        fifo_q.delete(); fifo_q.push_back(8'($urandom)); fifo_update();
        run_packet(8'($urandom), 1, "after_rst", 0, ns, nr);
    endtask

    initial begin
        rst = 1'b1;
        bus.tx_start = 1'b0; bus.tx_pid = 8'h00; bus.tx_byte_count = 7'd0;
        fifo_update();
        test_reset();
        test_basic_pid();
        test_stuffing();
        test_random();
        test_underrun();
        test_restart_ignored();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
